// File: rtl/ahb_mem_responder_if.sv
// AHB-Lite bus bundle between a master and the ahb_mem_responder memory slave.
interface ahb_mem_responder_if;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_mem_responder.sv
// AHB-Lite word memory slave with programmable wait states and a backdoor preload port.
// Define AHB_RESP_ERROR_EN to enable two-cycle ERROR responses for illegal/out-of-window transfers.
module ahb_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_LOG2  = 8,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ahb_mem_responder_if.slave    bus,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
`ifdef AHB_RESP_ERROR_EN
    localparam logic       ERR_EN    = 1'b1;
`else
    localparam logic       ERR_EN    = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic [31:0]           mem_q [DEPTH];

    logic [31:0] offset;
    logic        hready, hresp;
    logic [31:0] hrdata;
    logic        accept, addr_err, bus_wr;
    logic [3:0]  lane_en;
    logic [31:0] wr_word;

    assign offset = bus.HADDR - BASE_ADDR;
    assign accept = hready & bus.HTRANS[1];

`ifdef AHB_RESP_ERROR_EN
    assign addr_err = (offset[31:DEPTH_LOG2+2] != '0)
                   || (bus.HSIZE == 2'b11)
                   || (bus.HSIZE == 2'b01 && offset[0])
                   || (bus.HSIZE == 2'b10 && offset[1:0] != 2'b00);
`else
    // Without error responses the window simply wraps, so the high offset bits are ignored.
    logic unused_offset;
    assign unused_offset = ^offset[31:DEPTH_LOG2+2];
    assign addr_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 3'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all drive HREADY high, so each may take a new address phase.
                if (accept) begin
                    idx_d   = offset[DEPTH_LOG2+1:2];
                    off_d   = offset[1:0];
                    size_d  = bus.HSIZE;
                    write_d = bus.HWRITE;
                    cnt_d   = 3'd0;
                    if (addr_err)             state_d = S_ERR1;
                    else if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else                  state_d = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        case (state_q)
            S_WAIT: hready = 1'b0;
            S_DATA: if (!write_q) hrdata = mem_q[idx_q];
            S_ERR1: begin
                hready = 1'b0;
                hresp  = ERR_EN;
            end
            S_ERR2: hresp = ERR_EN;
            default: ;
        endcase
    end

    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign bus.HRDATA = hrdata;

    // Halfword lanes follow offset bit 1 only, which also aligns odd halfwords down.
    always_comb begin
        case (size_q)
            2'b00:   lane_en = 4'b0001 << off_q;
            2'b01:   lane_en = off_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = lane_en[i] ? bus.HWDATA[8*i +: 8] : mem_q[idx_q][8*i +: 8];
        end
    end

    // A reset edge during the DATA cycle aborts the write before it lands.
    assign bus_wr = (state_q == S_DATA) && write_q && !rst;

    always_ff @(posedge clk) begin
        if (bus_wr) mem_q[idx_q] <= wr_word;
        if (ld_en && !(bus_wr && ld_addr == idx_q)) mem_q[ld_addr] <= ld_data;
    end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Directed bench: one responder with one wait state, one with zero wait states.
module tb_ahb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_ld_en, b_ld_en;
    logic [7:0]  a_ld_addr, b_ld_addr;
    logic [31:0] a_ld_data, b_ld_data;
    int          n_checks = 0;
    int          n_fail   = 0;

    ahb_mem_responder_if a_if ();
    ahb_mem_responder_if b_if ();

    ahb_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_LOG2(8), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .bus(a_if),
        .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data)
    );

    ahb_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .bus(b_if),
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_preload(input logic [7:0] idx, input logic [31:0] data);
        a_ld_en   = 1'b1;
        a_ld_addr = idx;
        a_ld_data = data;
        step();
        a_ld_en   = 1'b0;
    endtask

    // One complete transfer on DUT a; returns read data, edges to completion and any HRESP seen.
    task automatic a_xfer(input logic [31:0] addr, input logic wr, input logic [1:0] sz,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int lat, output logic resp_seen);
        a_if.HTRANS = 2'b10;
        a_if.HADDR  = addr;
        a_if.HWRITE = wr;
        a_if.HSIZE  = sz;
        step();
        a_if.HTRANS = 2'b00;
        a_if.HWDATA = wdata;
        lat         = 1;
        resp_seen   = a_if.HRESP;
        while (a_if.HREADY !== 1'b1 && lat < 16) begin
            step();
            lat++;
            resp_seen |= a_if.HRESP;
        end
        rdata = a_if.HRDATA;
        step();
    endtask

    task automatic test_reset();
        a_if.HTRANS = 2'b00; a_if.HADDR = '0; a_if.HWRITE = 1'b0; a_if.HSIZE = 2'b10; a_if.HWDATA = '0;
        b_if.HTRANS = 2'b00; b_if.HADDR = '0; b_if.HWRITE = 1'b0; b_if.HSIZE = 2'b10; b_if.HWDATA = '0;
        a_ld_en = 1'b0; a_ld_addr = '0; a_ld_data = '0;
        b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0;
        rst = 1'b1;
        step();
        step();
        n_checks++; if (a_if.HREADY !== 1'b1) begin n_fail++; $display("FAIL reset_hready_a: got %b want 1", a_if.HREADY); end
        n_checks++; if (a_if.HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_hresp_a: got %b want 0", a_if.HRESP); end
        n_checks++; if (a_if.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata_a: got %h want 0", a_if.HRDATA); end
        n_checks++; if (b_if.HREADY !== 1'b1) begin n_fail++; $display("FAIL reset_hready_b: got %b want 1", b_if.HREADY); end
        n_checks++; if (b_if.HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_hresp_b: got %b want 0", b_if.HRESP); end
        n_checks++; if (b_if.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata_b: got %h want 0", b_if.HRDATA); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_wait_write_read();
        a_if.HTRANS = 2'b10; a_if.HADDR = 32'h10; a_if.HWRITE = 1'b1; a_if.HSIZE = 2'b10;
        step();
        a_if.HTRANS = 2'b00; a_if.HWDATA = 32'hDEADBEEF;
        n_checks++; if (a_if.HREADY !== 1'b0) begin n_fail++; $display("FAIL ww_wait_hready: got %b want 0", a_if.HREADY); end
        step();
        n_checks++; if (a_if.HREADY !== 1'b1) begin n_fail++; $display("FAIL ww_data_hready: got %b want 1", a_if.HREADY); end
        n_checks++; if (a_if.HRDATA !== 32'h0) begin n_fail++; $display("FAIL ww_data_hrdata: got %h want 0", a_if.HRDATA); end
        a_if.HTRANS = 2'b10; a_if.HADDR = 32'h10; a_if.HWRITE = 1'b0;
        step();
        a_if.HTRANS = 2'b00;
        n_checks++; if (a_if.HREADY !== 1'b0) begin n_fail++; $display("FAIL wr_wait_hready: got %b want 0", a_if.HREADY); end
        n_checks++; if (a_if.HRDATA !== 32'h0) begin n_fail++; $display("FAIL wr_wait_hrdata: got %h want 0", a_if.HRDATA); end
        step();
        n_checks++; if (a_if.HREADY !== 1'b1) begin n_fail++; $display("FAIL wr_data_hready: got %b want 1", a_if.HREADY); end
        n_checks++; if (a_if.HRDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data_hrdata: got %h want deadbeef", a_if.HRDATA); end
        n_checks++; if (a_if.HRESP !== 1'b0) begin n_fail++; $display("FAIL wr_data_hresp: got %b want 0", a_if.HRESP); end
        step();
        n_checks++; if (a_if.HRDATA !== 32'h0) begin n_fail++; $display("FAIL wr_idle_hrdata: got %h want 0", a_if.HRDATA); end
    endtask

    task automatic test_back_to_back();
        b_if.HTRANS = 2'b10; b_if.HADDR = 32'h8; b_if.HWRITE = 1'b1; b_if.HSIZE = 2'b10;
        step();
        n_checks++; if (b_if.HREADY !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_hready: got %b want 1", b_if.HREADY); end
        b_if.HWDATA = 32'h11223344;
        b_if.HTRANS = 2'b10; b_if.HADDR = 32'h8; b_if.HWRITE = 1'b0;
        step();
        b_if.HTRANS = 2'b00;
        n_checks++; if (b_if.HREADY !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_hready: got %b want 1", b_if.HREADY); end
        n_checks++; if (b_if.HRDATA !== 32'h11223344) begin n_fail++; $display("FAIL b2b_rd_hrdata: got %h want 11223344", b_if.HRDATA); end
        step();
        n_checks++; if (b_if.HRDATA !== 32'h0) begin n_fail++; $display("FAIL b2b_idle_hrdata: got %h want 0", b_if.HRDATA); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        int          lat;
        logic        resp;
        a_preload(8'd1, 32'hFFFFFFFF);
        a_xfer(32'h6, 1'b1, 2'b00, 32'h00AB0000, rd, lat, resp);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL byte_wr_latency: got %0d want 2", lat); end
        a_xfer(32'h4, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'hFFABFFFF) begin n_fail++; $display("FAIL byte_rd: got %h want ffabffff", rd); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL byte_rd_latency: got %0d want 2", lat); end
        a_preload(8'd2, 32'h12345678);
        a_xfer(32'hA, 1'b1, 2'b01, 32'hBEEF0000, rd, lat, resp);
        a_xfer(32'h8, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'hBEEF5678) begin n_fail++; $display("FAIL half_hi_rd: got %h want beef5678", rd); end
        a_xfer(32'h8, 1'b1, 2'b00, 32'h00000011, rd, lat, resp);
        a_xfer(32'h8, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'hBEEF5611) begin n_fail++; $display("FAIL byte0_rd: got %h want beef5611", rd); end
    endtask

    task automatic test_ld_priority();
        logic [31:0] rd;
        int          lat;
        logic        resp;
        a_if.HTRANS = 2'b10; a_if.HADDR = 32'hC; a_if.HWRITE = 1'b1; a_if.HSIZE = 2'b10;
        step();
        a_if.HTRANS = 2'b00; a_if.HWDATA = 32'h0BADF00D;
        step();
        a_ld_en = 1'b1; a_ld_addr = 8'd3; a_ld_data = 32'h12121212;
        step();
        a_ld_en = 1'b0;
        a_xfer(32'hC, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL ld_priority: got %h want 0badf00d", rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        int          lat;
        logic        resp;
        a_preload(8'd0, 32'hCAFE0000);
        a_if.HTRANS = 2'b10; a_if.HADDR = 32'h0; a_if.HWRITE = 1'b1; a_if.HSIZE = 2'b10;
        step();
        a_if.HTRANS = 2'b00; a_if.HWDATA = 32'h00000055;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (a_if.HREADY !== 1'b1) begin n_fail++; $display("FAIL abort_wait_hready: got %b want 1", a_if.HREADY); end
        n_checks++; if (a_if.HRESP !== 1'b0) begin n_fail++; $display("FAIL abort_wait_hresp: got %b want 0", a_if.HRESP); end
        a_xfer(32'h0, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'hCAFE0000) begin n_fail++; $display("FAIL abort_wait_rd: got %h want cafe0000", rd); end
        a_if.HTRANS = 2'b10; a_if.HADDR = 32'h0; a_if.HWRITE = 1'b1; a_if.HSIZE = 2'b10;
        step();
        a_if.HTRANS = 2'b00; a_if.HWDATA = 32'h00000055;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_xfer(32'h0, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'hCAFE0000) begin n_fail++; $display("FAIL abort_data_rd: got %h want cafe0000", rd); end
    endtask

`ifdef AHB_RESP_ERROR_EN
    task automatic test_error_response();
        logic [31:0] rd;
        int          lat;
        logic        resp;
        a_preload(8'd0, 32'h600DF00D);
        a_if.HTRANS = 2'b10; a_if.HADDR = 32'h400; a_if.HWRITE = 1'b0; a_if.HSIZE = 2'b10;
        step();
        a_if.HTRANS = 2'b00;
        n_checks++; if (a_if.HREADY !== 1'b0) begin n_fail++; $display("FAIL err1_hready: got %b want 0", a_if.HREADY); end
        n_checks++; if (a_if.HRESP !== 1'b1) begin n_fail++; $display("FAIL err1_hresp: got %b want 1", a_if.HRESP); end
        n_checks++; if (a_if.HRDATA !== 32'h0) begin n_fail++; $display("FAIL err1_hrdata: got %h want 0", a_if.HRDATA); end
        step();
        n_checks++; if (a_if.HREADY !== 1'b1) begin n_fail++; $display("FAIL err2_hready: got %b want 1", a_if.HREADY); end
        n_checks++; if (a_if.HRESP !== 1'b1) begin n_fail++; $display("FAIL err2_hresp: got %b want 1", a_if.HRESP); end
        a_if.HTRANS = 2'b10; a_if.HADDR = 32'h2; a_if.HWRITE = 1'b1; a_if.HSIZE = 2'b10;
        step();
        a_if.HTRANS = 2'b00; a_if.HWDATA = 32'hFFFFFFFF;
        n_checks++; if (a_if.HRESP !== 1'b1) begin n_fail++; $display("FAIL misalign_hresp: got %b want 1", a_if.HRESP); end
        step();
        a_xfer(32'h0, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'h600DF00D) begin n_fail++; $display("FAIL err_mem_unchanged: got %h want 600df00d", rd); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL err2_accept_latency: got %0d want 2", lat); end
        n_checks++; if (resp !== 1'b0) begin n_fail++; $display("FAIL err2_accept_hresp: got %b want 0", resp); end
    endtask
`else
    task automatic test_wrap_align();
        logic [31:0] rd;
        int          lat;
        logic        resp;
        a_preload(8'd5, 32'h5A5A5A5A);
        a_xfer(32'h414, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL wrap_rd: got %h want 5a5a5a5a", rd); end
        n_checks++; if (resp !== 1'b0) begin n_fail++; $display("FAIL wrap_hresp: got %b want 0", resp); end
        a_xfer(32'h17, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL align_word_rd: got %h want 5a5a5a5a", rd); end
        a_xfer(32'h18, 1'b1, 2'b11, 32'h01020304, rd, lat, resp);
        a_xfer(32'h18, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'h01020304) begin n_fail++; $display("FAIL size11_rd: got %h want 01020304", rd); end
        a_xfer(32'h19, 1'b1, 2'b01, 32'h0000BBBB, rd, lat, resp);
        a_xfer(32'h18, 1'b0, 2'b10, 32'h0, rd, lat, resp);
        n_checks++; if (rd !== 32'h0102BBBB) begin n_fail++; $display("FAIL align_half_rd: got %h want 0102bbbb", rd); end
        n_checks++; if (resp !== 1'b0) begin n_fail++; $display("FAIL align_hresp: got %b want 0", resp); end
    endtask
`endif

    initial begin
        test_reset();
        test_wait_write_read();
        test_back_to_back();
        test_byte_lanes();
        test_ld_priority();
        test_reset_abort();
`ifdef AHB_RESP_ERROR_EN
        test_error_response();
`else
        test_wrap_align();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_mem_responder.md
AHB_MEM_RESPONDER -- requirements
Module: ahb_mem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte base of the responder window.
REQ-002 Parameter DEPTH_LOG2, default 8, log2 of memory depth in 32-bit words.
REQ-003 Parameter WAIT_CYCLES, default 1, range 0-7, wait states per OKAY transfer.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 HTRANS  input  2  transfer type; bit 1 set = NONSEQ/SEQ (valid), else IDLE/BUSY.
REQ-007 HADDR  input  32  byte address, address phase.
REQ-008 HWRITE  input  1  1 = write, address phase.
REQ-009 HSIZE  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 HWDATA  input  32  write data, data phase.
REQ-011 HRDATA  output  32  read data, valid when HREADY=1 in a read data phase.
REQ-012 HREADY  output  1  data-phase completion; also qualifies next address phase.
REQ-013 HRESP  output  1  0 OKAY, 1 ERROR.
REQ-014 ld_en  input  1  backdoor preload strobe, valid only while no transfer is in progress.
REQ-015 ld_addr  input  DEPTH_LOG2  backdoor word index.
REQ-016 ld_data  input  32  backdoor word written when ld_en=1.

Function
REQ-017 Address phase accepted on a rising edge where HREADY=1 and HTRANS[1]=1; HADDR/HWRITE/HSIZE latched.
REQ-018 FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-019 IDLE: no pending data phase; HREADY=1, HRESP=0.
REQ-020 Accepted OKAY transfer -> WAIT if WAIT_CYCLES>0 (counter loaded WAIT_CYCLES-1), else DATA.
REQ-021 WAIT: HREADY=0, HRESP=0; counter decrements; at 0 -> DATA.
REQ-022 DATA: HREADY=1, HRESP=0; a new accepted transfer in this cycle starts its own phase (back-to-back, no idle gap).
REQ-023 Write commits on the DATA-cycle edge: byte lanes per HSIZE and HADDR[1:0], little-endian; unselected bytes unchanged.
REQ-024 Read: HRDATA holds full addressed word in DATA cycle; 0 in all other cycles.
REQ-025 Write immediately followed by read of same word: read returns the newly written bytes (forwarding required when WAIT_CYCLES=0).
REQ-026 Word index = (HADDR-BASE_ADDR)>>2, truncated to DEPTH_LOG2 bits.
REQ-027 ld_en has lower priority than a committing bus write to the same index; bus write wins.
REQ-028 Latency: read data returned exactly WAIT_CYCLES+1 cycles after address-phase edge.

Reset
REQ-029 rst=1: state IDLE, HREADY=1, HRESP=0, HRDATA=0, wait counter 0, latched phase cleared.
REQ-030 Reset during WAIT or DATA aborts the transfer; pending write not committed.
REQ-031 Memory contents not cleared by reset.

Configuration
REQ-032 Macro AHB_RESP_ERROR_EN.
REQ-033 Defined: out-of-window address, HSIZE=11, or misalignment (halfword at odd addr, word not 4-aligned) -> ERR1 (HREADY=0, HRESP=1) then ERR2 (HREADY=1, HRESP=1) then normal; no memory write, HRDATA=0; no wait states applied.
REQ-034 Defined: transfer accepted during ERR2 proceeds normally.
REQ-035 Not defined: HRESP tied 0; addresses wrap modulo depth; HSIZE=11 treated as word; misaligned addresses aligned down; ERR1/ERR2 unreachable.

Verification
REQ-036 WAIT_CYCLES=1: write word 0xDEADBEEF @0x10, then read @0x10 -> HREADY low 1 cycle each, HRDATA=0xDEADBEEF.
REQ-037 WAIT_CYCLES=0: back-to-back write 0x11223344 @0x8 then read @0x8 -> read returns 0x11223344 next cycle.
REQ-038 Preload 0xFFFFFFFF @index 1; byte write 0xAB @0x6 -> read @0x4 returns 0xFFABFFFF.
REQ-039 AHB_RESP_ERROR_EN defined: read @BASE_ADDR+0x400 (DEPTH_LOG2=8) -> ERR1 then ERR2, HRESP=1 both cycles; memory unchanged.
REQ-040 rst asserted in WAIT of a write 0x55 @0x0 -> next cycle HREADY=1, HRESP=0; read @0x0 returns prior value.
